mac_accum: RTL and testbench
============================

Name: mac_accum

Overview:
- Accumulates a frame of LEN signed products from the N-bit signed multiplier stage; sits directly downstream of that stage.
- Uses a valid/ready handshake on input and output and holds each frame sum until the consumer accepts it.
- Forms the accumulate half of the team's multiply-accumulate datapath (FIR taps, dot products).

Parameters:
- N, 9, operand width of the upstream multiplier; product width is 2*N.
- LEN, 8, products per frame; must be >= 2.
- ACC_W, 2*N+$clog2(LEN), signed accumulator and result width; guarantees no overflow for any LEN products.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous frame abort; discards the partial sum.
- prod  input  2*N  signed product from the multiplier.
- prod_valid  input  1  prod is valid this cycle.
- prod_ready  output  1  block accepts prod this cycle.
- acc_out  output  ACC_W  signed frame sum.
- acc_valid  output  1  acc_out holds a complete frame sum.
- acc_ready  input  1  consumer accepts acc_out.
- cnt  output  $clog2(LEN)+1  number of products accepted in the current frame.

Behaviour:
- Reset and clock: one clock; reset is synchronous and active-high.
- Reset values: acc_out=0, acc_valid=0, cnt=0, internal sum=0, state=ACCUM. prod_ready=1 in the cycle after rst deasserts.
- Input handshake: a transfer occurs on a rising edge when prod_valid && prod_ready.
- Output handshake: a transfer occurs on a rising edge when acc_valid && acc_ready.
- State ACCUM:
  - prod_ready=1, acc_valid=0.
  - On each transfer: sum <= sum + sign-extend(prod) to ACC_W; cnt <= cnt+1.
  - On the transfer where cnt==LEN-1: acc_out <= sum + sext(prod); sum <= 0; cnt <= 0; go to HOLD.
  - No transfer: sum and cnt hold.
- State HOLD:
  - prod_ready=0, acc_valid=1.
  - acc_out, and therefore the frame sum, is stable until accepted.
  - On output transfer: acc_valid <= 0; go to ACCUM. prod_ready is 1 in the next cycle, with no same-cycle bypass.
- Latency: acc_valid rises on the edge that accepts the LEN-th product; acc_out is registered.
- Throughput: at most one frame per LEN+1 cycles.
- Arithmetic:
  - Two's-complement throughout; prod is sign-extended.
  - No saturation or wrap is possible by construction of ACC_W.
  - Parameter check: ACC_W < 2*N+$clog2(LEN) is a parameter error, flagged in simulation.
- clr:
  - In ACCUM: sum <= 0 and cnt <= 0. Any product presented in the same cycle is dropped; clr wins over the transfer.
  - In HOLD: no effect. A completed result is never discarded by clr.
- rst mid-frame or in HOLD: all state returns to the reset values on that edge. A pending result is lost and acc_valid drops on the next edge.
- prod_valid low between products: gaps of any length are allowed; the accumulation is unaffected.
- acc_ready high while acc_valid=0: ignored.
- prod_ready depends only on state and is registered-state driven, with no combinational path from acc_ready.

Test Plan:
- Basic frame: N=9, LEN=8, eight products of +1, back-to-back; acc_ready=1 -> acc_valid rises on the 8th accepted edge with acc_out=8; cnt returns to 0; prod_ready=0 for exactly one cycle.
- Extremes:
  - Eight products of +65536 (x1=x2=-256) -> acc_out=524288.
  - Eight products of -65280 (-256*255) -> acc_out=-522240 (21-bit 0x180800).
  - No overflow in either case.
- Backpressure: complete a frame, hold acc_ready=0 for 5 cycles while prod_valid=1 -> acc_out stable, acc_valid=1, prod_ready=0 for all 5 cycles, and no products are consumed. On release, the next frame starts clean at sum 0.
- Gaps and clr:
  - Frame with prod_valid toggling 1/0 and values 3,-5,7,... -> correct sum.
  - Assert clr after 4 products of 10, together with a product of 99 -> cnt=0 and 99 dropped; the next 8 products of 2 give acc_out=16.
  - clr asserted during HOLD -> result unchanged and still delivered.
- Reset: rst after 5 products, and separately rst during HOLD -> next edge gives acc_valid=0, cnt=0, acc_out=0. The following frame of eight +1 gives 8.

Source files
------------

// File: rtl/mac_accum.sv
// Frame accumulator for the signed multiplier stage: sums LEN products per frame
// and holds each frame sum behind a valid/ready handshake until it is taken.
module mac_accum #(
    parameter int N     = 9,
    parameter int LEN   = 8,
    parameter int ACC_W = 2*N + $clog2(LEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic signed [2*N-1:0]    prod,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic                     acc_valid,
    input  logic                     acc_ready,
    output logic [$clog2(LEN):0]     cnt
);

    localparam int CNT_W     = $clog2(LEN) + 1;
    localparam int MIN_ACC_W = 2*N + $clog2(LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                    state;
    state_t                    state_next;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   sum_plus;
    logic                      take;
    logic                      last;

    // Handshake outputs come from the state register only, so acc_ready never
    // reaches prod_ready combinationally.
    always_comb begin
        prod_ext   = {{(ACC_W - 2*N){prod[2*N-1]}}, prod};
        sum_plus   = sum + prod_ext;
        take       = (state == ACCUM) && prod_valid && !clr;
        last       = (cnt == LAST_CNT);
        state_next = state;
        prod_ready = 1'b0;
        acc_valid  = 1'b0;
        case (state)
            ACCUM: begin
                prod_ready = 1'b1;
                if (take && last) state_next = HOLD;
            end
            HOLD: begin
                acc_valid = 1'b1;
                if (acc_ready) state_next = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_next;
    end

    // clr only aborts a partial frame; a completed sum waiting in HOLD survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum     <= '0;
            cnt     <= '0;
            acc_out <= '0;
        end else if (state == ACCUM) begin
            if (clr) begin
                sum <= '0;
                cnt <= '0;
            end else if (take) begin
                if (last) begin
                    acc_out <= sum_plus;
                    sum     <= '0;
                    cnt     <= '0;
                end else begin
                    sum <= sum_plus;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        assert (ACC_W >= MIN_ACC_W && LEN >= 2)
            else $error("mac_accum: ACC_W too narrow for LEN products, or LEN < 2");
    end

endmodule

// File: tb/tb_mac_accum.sv
// Self-checking bench for mac_accum: directed frames plus randomized traffic,
// all checked every cycle against a frame-level reference model.
module tb_mac_accum;

    localparam int N     = 9;
    localparam int LEN   = 8;
    localparam int ACC_W = 2*N + $clog2(LEN);

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     clr;
    logic signed [2*N-1:0]    prod;
    logic                     prod_valid;
    logic                     prod_ready;
    logic signed [ACC_W-1:0]  acc_out;
    logic                     acc_valid;
    logic                     acc_ready;
    logic [$clog2(LEN):0]     cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: products accepted into the open frame, and the last frame result.
    int     frameQ[$];
    bit     holding;
    longint result;

    mac_accum #(.N(N), .LEN(LEN), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .cnt        (cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare everything.
    task automatic applyStimulus(input bit r, input bit c, input bit pv, input int pval, input bit ar);
        longint s;
        rst        = r;
        clr        = c;
        prod_valid = pv;
        prod       = (2*N)'(pval);
        acc_ready  = ar;
        @(posedge clk);
        if (r) begin
            frameQ.delete();
            holding = 1'b0;
            result  = 0;
        end else if (holding) begin
            if (ar) holding = 1'b0;
        end else if (c) begin
            frameQ.delete();
        end else if (pv) begin
            frameQ.push_back(pval);
            if (frameQ.size() == LEN) begin
                s = 0;
                foreach (frameQ[i]) s += frameQ[i];
                result  = s;
                holding = 1'b1;
                frameQ.delete();
            end
        end
        #1;
        checkOutput("acc_valid",  acc_valid,  holding);
        checkOutput("prod_ready", prod_ready, !holding);
        checkOutput("cnt",        cnt,        frameQ.size());
        checkOutput("acc_out",    acc_out,    result);
    endtask

    task automatic sendFrame(input int val, input bit ar);
        repeat (LEN) applyStimulus(1'b0, 1'b0, 1'b1, val, ar);
    endtask

    initial begin
        int gapVals[8] = '{3, -5, 7, -9, 11, -13, 15, -17};
        int a, b;
        bit r, c, pv, ar;

        rst = 1'b1; clr = 1'b0; prod_valid = 1'b0; prod = '0; acc_ready = 1'b0;
        holding = 1'b0; result = 0;

        // Reset values
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
        checkOutput("rst_valid", acc_valid, 0);
        checkOutput("rst_cnt",   cnt,       0);
        checkOutput("rst_out",   acc_out,   0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0);
        checkOutput("rst_ready", prod_ready, 1);

        // Basic back-to-back frame of +1
        sendFrame(1, 1'b1);
        checkOutput("basic_out",   acc_out,   8);
        checkOutput("basic_valid", acc_valid, 1);
        checkOutput("basic_cnt",   cnt,       0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1, 1'b1);
        checkOutput("basic_nobypass", cnt, 0);
        checkOutput("basic_ready",    prod_ready, 1);

        // Extremes
        sendFrame(65536, 1'b1);
        checkOutput("ext_pos", acc_out, 524288);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
        sendFrame(-65280, 1'b1);
        checkOutput("ext_neg", acc_out, -522240);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);

        // Backpressure with products offered
        sendFrame(4, 1'b0);
        repeat (5) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 77, 1'b0);
            checkOutput("bp_out",   acc_out,    32);
            checkOutput("bp_valid", acc_valid,  1);
            checkOutput("bp_ready", prod_ready, 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
        checkOutput("bp_cnt", cnt, 0);
        sendFrame(1, 1'b1);
        checkOutput("bp_next", acc_out, 8);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);

        // Gaps between products
        for (int i = 0; i < LEN; i++) begin
            if (i > 0) applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
            applyStimulus(1'b0, 1'b0, 1'b1, gapVals[i], 1'b1);
        end
        checkOutput("gap_out", acc_out, -8);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);

        // clr mid-frame drops the partial sum and the coincident product
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 10, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 99, 1'b1);
        checkOutput("clr_cnt", cnt, 0);
        sendFrame(2, 1'b1);
        checkOutput("clr_out", acc_out, 16);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);

        // clr during HOLD leaves the result intact
        sendFrame(5, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b0);
        checkOutput("clrhold_out",   acc_out,   40);
        checkOutput("clrhold_valid", acc_valid, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
        checkOutput("clrhold_done", acc_valid, 0);

        // Reset mid-frame
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
        checkOutput("rstmid_cnt", cnt,     0);
        checkOutput("rstmid_out", acc_out, 0);
        sendFrame(1, 1'b1);
        checkOutput("rstmid_next", acc_out, 8);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);

        // Reset during HOLD
        sendFrame(3, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
        checkOutput("rsthold_valid", acc_valid, 0);
        checkOutput("rsthold_out",   acc_out,   0);
        checkOutput("rsthold_cnt",   cnt,       0);
        sendFrame(1, 1'b1);
        checkOutput("rsthold_next", acc_out, 8);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            c  = ($urandom_range(0, 19) == 0);
            pv = ($urandom_range(0, 3) != 0);
            ar = ($urandom_range(0, 2) != 0);
            a  = int'($urandom_range(0, 511)) - 256;
            b  = int'($urandom_range(0, 511)) - 256;
            applyStimulus(r, c, pv, a * b, ar);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
